// File: rtl/mdu_seq.sv
// Sequential unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// All arithmetic goes through an external shared 32-bit ALU.
module mdu_seq #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_ltu
);

  localparam int unsigned CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic [3:0] ALU_IDLE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_a, r_b, r_hi, r_lo, r_result;
  logic [1:0]      r_op;
  logic [CW-1:0]   r_count;

  logic [XLEN-1:0] w_hi_nxt, w_lo_nxt, w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic            w_carry, w_qbit, w_div0;

  // r_hi/r_lo hold {hi,lo} for multiply and {rem,quo} for divide
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = ALU_IDLE;
    w_sum    = r_hi;
    w_carry  = 1'b0;
    w_rem_sh = '0;
    w_qbit   = 1'b0;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_state == RUN) begin
      if (!r_op[1]) begin
        alu_op = ALU_ADD;
        alu_a  = r_hi;
        alu_b  = r_a;
        if (r_lo[0]) begin
          w_sum   = alu_result;
          w_carry = (alu_result < r_hi);
        end
        w_hi_nxt = {w_carry, w_sum[XLEN-1:1]};
        w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
      end else begin
        w_rem_sh = {r_hi, r_lo[XLEN-1]};
        alu_op   = ALU_SUB;
        alu_a    = w_rem_sh[XLEN-1:0];
        alu_b    = r_b;
        if (w_rem_sh[XLEN] || !alu_ltu) begin
          w_hi_nxt = alu_result;
          w_qbit   = 1'b1;
        end else begin
          w_hi_nxt = w_rem_sh[XLEN-1:0];
        end
        w_lo_nxt = {r_lo[XLEN-2:0], w_qbit};
      end
    end
  end

  assign w_div0 = op[1] && (b == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_div0 ? FIN : RUN;
      RUN:     if (r_count == LAST) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // result is loaded on the edge entering FIN so it is valid while done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= op[1] ? a : b;
            if (w_div0) r_result <= op[0] ? a : '1;
          end
        end
        RUN: begin
          r_hi    <= w_hi_nxt;
          r_lo    <= w_lo_nxt;
          r_count <= r_count + 1'b1;
          if (r_count == LAST) r_result <= r_op[0] ? w_hi_nxt : w_lo_nxt;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == FIN);
  assign result = r_result;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq with a behavioural model of the shared ALU.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_ltu;

  mdu_seq #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_ltu(alu_ltu)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      4'b0001: alu_result = alu_a + alu_b;
      4'b0010: alu_result = alu_a - alu_b;
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_ltu = (alu_a < alu_b);

  typedef struct {
    int          id;
    logic [31:0] res;
    int          t0;
    int          lat;
    int          busy_cycles;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops and compares on every done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (!busy) begin
        chk("idle_alu_op", {28'h0, alu_op}, 32'h0);
        if (alu_a !== 32'h0 || alu_b !== 32'h0) chk("idle_alu_ab", alu_a | alu_b, 32'h0);
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", {31'h0, done}, 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("result_%0d", e.id), result, e.res);
          chk($sformatf("latency_%0d", e.id), cyc - e.t0, e.lat);
          chk($sformatf("busy_cycles_%0d", e.id), busy_cnt, e.busy_cycles);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input int id, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] res, input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    e.id = id; e.res = res; e.t0 = cyc; e.lat = lat;
    e.busy_cycles = (lat == 33) ? 32 : 0;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("timeout_waiting_done", 32'(q.size()), 32'h0);
      q.delete();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    rst_n = 1'b1;

    issue(1, 2'b00, 32'h7, 32'h6, 32'h2A, 33);                     wait_empty();
    issue(2, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33); wait_empty();
    issue(3, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33); wait_empty();
    issue(4, 2'b10, 32'd100, 32'd7, 32'd14, 33);                   wait_empty();
    issue(5, 2'b11, 32'd100, 32'd7, 32'd2, 33);                    wait_empty();
    issue(6, 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1, 33);      wait_empty();
    issue(7, 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33); wait_empty();
    issue(8, 2'b10, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1);       wait_empty();
    issue(9, 2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);       wait_empty();

    // Start pulsed mid-run with different operands must be ignored
    issue(10, 2'b00, 32'h0001_0003, 32'h0000_0100, 32'h0100_0300, 33);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    // Reset during RUN aborts without a done pulse
    issue(11, 2'b00, 32'd1234, 32'd5678, 32'd0, 33);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_result", result, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_result_held", result, 32'h0);

    issue(12, 2'b00, 32'd3, 32'd5, 32'd15, 33); wait_empty();
    repeat (3) @(negedge clk);
    chk("result_held_after_done", result, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer for the single-cycle core's RV32M subset (MUL, MULHU, DIVU, REMU).
- Owns no adder. It drives a 32-bit ALU instance through an operand/opcode port each iteration and consumes its result and unsigned-less-than flag.
- Sits beside the main datapath. The core stalls its PC while busy is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  00=MUL (low 32), 01=MULHU (high 32), 10=DIVU, 11=REMU
- a  in  32  multiplicand / dividend
- b  in  32  multiplier / divisor
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse; result valid this cycle and held until next start
- result  out  32  registered result
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_op  out  4  ALU opcode: 0001 ADD, 0010 SUB, 0000 idle (ALU outputs 0)
- alu_result  in  32  ALU result, combinational from alu_a/alu_b/alu_op
- alu_ltu  in  1  ALU unsigned flag, alu_a < alu_b

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, alu_a=0, alu_b=0, alu_op=0000, count=0, internal acc/quotient/remainder regs=0.
- States: IDLE, RUN, FIN.
- IDLE: on start=1, latch a, b, op; count=0. Then:
  - DIVU/REMU with b==0 go to FIN, with quotient=FFFFFFFF and remainder=a (RV32M rule).
  - Otherwise go to RUN.
- RUN: busy=1. Exactly ITER cycles, count 0..31. After count==31, go to FIN.
- FIN: done=1 for one cycle, busy=0, result register loaded, then IDLE.
- Latency: accepted start at cycle T gives done at T+ITER+1 (T+33). Divide-by-zero gives done at T+1.
- Multiply iteration (shift-add, 64-bit {hi,lo}, lo initialised to b, hi to 0):
  - alu_op=ADD, alu_a=hi, alu_b=latched a.
  - If lo[0]=1: sum=alu_result, carry=(alu_result < hi), computed internally from the 32-bit compare. Else: sum=hi, carry=0.
  - Then {hi,lo} <= {carry,sum,lo[31:1]}.
  - MUL returns lo; MULHU returns hi.
- Divide iteration (restoring; rem init 0, quo init a):
  - Form {ov,rem'} = {rem,quo[31]} as 33 bits.
  - Drive alu_op=SUB, alu_a=rem', alu_b=divisor.
  - If ov=1 or alu_ltu=0: rem <= alu_result, quotient bit=1.
  - Else: rem <= rem', quotient bit=0.
  - quo <= {quo[30:0],qbit}.
  - DIVU returns quo; REMU returns rem.
- ALU drive rules:
  - alu_* are combinational from state/regs and valid only in RUN.
  - Outside RUN, alu_op=0000 and alu_a=alu_b=0, so the sequencer never perturbs a shared ALU while idle.
- start while busy or in FIN: ignored; no queueing.
- a/b/op changes after acceptance have no effect (latched).
- Reset mid-RUN aborts immediately: no done pulse, result returns to 0.
- done and start in the same cycle: done is from FIN, so start is not sampled until the next IDLE cycle. Back-to-back throughput is one op per 34 cycles.
- All arithmetic is unsigned modulo 2^32 except the internal 33-bit remainder shift and the 64-bit product.

Test Plan:
- MUL a=0x0000_0007, b=0x0000_0006 -> done at start+33, result=0x0000_002A; busy high exactly 32 cycles.
- MULHU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> result=0xFFFF_FFFE; MUL same operands -> 0x0000_0001 (carry path).
- DIVU a=100, b=7 -> result=14; REMU a=100, b=7 -> result=2; DIVU a=0xFFFF_FFFF, b=0x8000_0001 -> 1 (ov path exercised).
- DIVU a=0x1234_5678, b=0 -> done at start+1, result=0xFFFF_FFFF; REMU same -> 0x1234_5678.
- start pulsed again at cycle 10 of a run with different a/b -> ignored; first result correct; alu_op=0000 in every non-RUN cycle.
- rst_n low at RUN cycle 15 -> busy=0, done never pulses, result=0. A fresh MUL 3*5 afterwards gives 15.
